// File: rtl/branch_decoder_unit_pkg.sv
// Shared encodings for the EX-stage next-PC source selection.
// Consumed by the branch decoder and the fetch controller.
package branch_decoder_unit_pkg;

    localparam logic [1:0] PcPlus4Src             = 2'b00;
    localparam logic [1:0] SepcSrc                = 2'b01;
    localparam logic [1:0] MepcSrc                = 2'b10;
    localparam logic [1:0] PcOrReadDataPlusImmSrc = 2'b11;

endpackage

// File: rtl/pc_fetch_controller_pkg.sv
// Types shared by the instruction-fetch sequencing controller.
// Holds the fetch FSM state encoding.
package pc_fetch_controller_pkg;

    typedef enum logic [1:0] {
        Boot  = 2'd0,
        Fetch = 2'd1,
        Hold  = 2'd2,
        Drain = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_controller.sv
// Owns the architectural PC and issues single-outstanding fetches.
// Redirects flush the front-end and drain any wrong-path fetch.
module pc_fetch_controller
    import branch_decoder_unit_pkg::*;
    import pc_fetch_controller_pkg::*;
#(
    parameter int unsigned      Width       = 32,
    parameter logic [Width-1:0] ResetVector = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             branch_valid,
    input  logic [1:0]       pc_src,
    input  logic [Width-1:0] target_addr,
    input  logic [Width-1:0] sepc,
    input  logic [Width-1:0] mepc,
    input  logic             stall,
    input  logic             fetch_ack,
    output logic             fetch_req,
    output logic [Width-1:0] fetch_addr,
    output logic [Width-1:0] pc,
    output logic             instr_valid,
    output logic             flush
);

    fetch_state_t     state;
    logic [Width-1:0] pcReg;
    logic [Width-1:0] pending;
    logic [Width-1:0] rawTarget;
    logic [Width-1:0] target;
    logic             redirect;

    assign redirect = branch_valid && (pc_src != PcPlus4Src);

    always_comb begin
        rawTarget = target_addr;
        unique case (1'b1)
            (pc_src == SepcSrc):                rawTarget = sepc;
            (pc_src == MepcSrc):                rawTarget = mepc;
            (pc_src == PcOrReadDataPlusImmSrc): rawTarget = target_addr;
            (pc_src == PcPlus4Src):             rawTarget = target_addr;
        endcase
    end

    // Targets are always word aligned; low bits from EX are discarded.
    assign target = {rawTarget[Width-1:2], 2'b00};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= Boot;
            pcReg   <= ResetVector;
            pending <= '0;
        end else begin
            unique case (state)
                Boot: begin
                    state <= Fetch;
                end
                Fetch: begin
                    if (fetch_ack) begin
                        if (redirect) begin
                            pcReg <= target;
                        end else begin
                            pcReg <= pcReg + Width'(4);
                            if (stall) state <= Hold;
                        end
                    end else if (redirect) begin
                        pending <= target;
                        state   <= Drain;
                    end
                end
                Hold: begin
                    if (redirect) begin
                        pcReg <= target;
                        state <= Fetch;
                    end else if (!stall) begin
                        state <= Fetch;
                    end
                end
                Drain: begin
                    // Latest redirect wins, even on the ack cycle itself.
                    if (fetch_ack) begin
                        pcReg <= redirect ? target : pending;
                        state <= Fetch;
                    end else if (redirect) begin
                        pending <= target;
                    end
                end
                default: state <= Boot;
            endcase
        end
    end

    assign fetch_req   = (state == Fetch) || (state == Drain);
    assign fetch_addr  = pcReg;
    assign pc          = pcReg;
    assign instr_valid = (state == Fetch) && fetch_ack && !redirect;
    assign flush       = redirect && (state != Boot);

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed scenarios plus random traffic against a behavioural
// model of the fetch controller.
module tb_pc_fetch_controller;

    localparam logic [31:0] Rv    = 32'h100;
    localparam logic [32:0] NoChk = 33'h1_0000_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        branch_valid = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] target_addr = '0;
    logic [31:0] sepc = '0;
    logic [31:0] mepc = '0;
    logic        stall = 1'b0;
    logic        fetch_ack = 1'b0;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        flush;

    int nChecks = 0;
    int nErrors = 0;

    // Model: where the fetcher is, what it owes, and where it goes next.
    bit          mBoot;
    bit          mHold;
    bit          mDrain;
    logic [31:0] mPc;
    logic [31:0] mPend;

    pc_fetch_controller #(
        .Width(32),
        .ResetVector(Rv)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .branch_valid(branch_valid),
        .pc_src(pc_src),
        .target_addr(target_addr),
        .sepc(sepc),
        .mepc(mepc),
        .stall(stall),
        .fetch_ack(fetch_ack),
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .pc(pc),
        .instr_valid(instr_valid),
        .flush(flush)
    );

    always #5 clock = ~clock;

    task automatic checkEq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mBoot  = 1'b1;
        mHold  = 1'b0;
        mDrain = 1'b0;
        mPc    = Rv;
        mPend  = '0;
    endtask

    // Called just after a falling edge; returns at the next one.
    task automatic step(input bit bv, input logic [1:0] src,
                        input logic [31:0] tgt, input bit ack,
                        input bit stl, input logic [32:0] want);
        bit          redir;
        logic [31:0] dest;
        bit          expReq;
        bit          expValid;
        bit          expFlush;
        branch_valid = bv;
        pc_src       = src;
        target_addr  = tgt;
        fetch_ack    = ack;
        stall        = stl;
        #1;
        redir = bv && (src != 2'b00);
        case (src)
            2'b01:   dest = sepc;
            2'b10:   dest = mepc;
            default: dest = tgt;
        endcase
        dest = dest & ~32'h3;
        expReq   = !mBoot && !mHold;
        expValid = expReq && !mDrain && ack && !redir;
        expFlush = redir && !mBoot;
        checkEq("fetch_req", 32'(fetch_req), 32'(expReq));
        checkEq("instr_valid", 32'(instr_valid), 32'(expValid));
        checkEq("flush", 32'(flush), 32'(expFlush));
        checkEq("pc", pc, mPc);
        if (expReq) checkEq("fetch_addr", fetch_addr, mPc);
        if (!want[32]) checkEq("want_addr", fetch_addr, want[31:0]);
        if (mBoot) begin
            mBoot = 1'b0;
        end else if (mHold) begin
            if (redir) begin
                mPc   = dest;
                mHold = 1'b0;
            end else if (!stl) begin
                mHold = 1'b0;
            end
        end else if (mDrain) begin
            if (ack) begin
                mPc    = redir ? dest : mPend;
                mDrain = 1'b0;
            end else if (redir) begin
                mPend = dest;
            end
        end else if (ack) begin
            if (redir) begin
                mPc = dest;
            end else begin
                mPc   = mPc + 32'd4;
                mHold = stl;
            end
        end else if (redir) begin
            mPend  = dest;
            mDrain = 1'b1;
        end
        @(negedge clock);
    endtask

    initial begin
        modelReset();
        sepc = 32'h500;
        mepc = 32'h80;
        branch_valid = 1'b1;
        pc_src = 2'b11;
        repeat (2) @(negedge clock);
        checkEq("rst_req", 32'(fetch_req), 32'd0);
        checkEq("rst_valid", 32'(instr_valid), 32'd0);
        checkEq("rst_flush", 32'(flush), 32'd0);
        checkEq("rst_pc", pc, Rv);
        reset_n = 1'b1;

        // Boot and sequential fetch
        step(0, 2'b00, 0, 1, 0, NoChk);
        step(0, 2'b00, 0, 1, 0, 33'h100);
        step(0, 2'b00, 0, 1, 0, 33'h104);
        step(0, 2'b00, 0, 1, 0, 33'h108);
        // Jump with same-cycle ack
        step(1, 2'b11, 32'h200, 1, 0, 33'h10C);
        step(1, 2'b11, 32'h403, 1, 0, 33'h200);
        step(0, 2'b00, 0, 1, 0, 33'h400);
        // Drain to MEPC
        step(1, 2'b11, 32'h300, 1, 0, 33'h404);
        step(0, 2'b00, 0, 0, 0, 33'h300);
        step(1, 2'b10, 0, 0, 0, 33'h300);
        step(0, 2'b00, 0, 0, 0, 33'h300);
        step(0, 2'b00, 0, 1, 0, 33'h300);
        step(0, 2'b00, 0, 1, 0, 33'h80);
        // Double redirect while draining
        step(0, 2'b00, 0, 0, 0, 33'h84);
        step(1, 2'b01, 0, 0, 0, 33'h84);
        step(1, 2'b11, 32'h600, 0, 0, 33'h84);
        step(0, 2'b00, 0, 1, 0, 33'h84);
        step(0, 2'b00, 0, 1, 0, 33'h600);
        // Stall into HOLD, then release
        step(0, 2'b00, 0, 1, 1, 33'h604);
        step(0, 2'b00, 0, 1, 1, NoChk);
        step(0, 2'b00, 0, 0, 0, NoChk);
        step(0, 2'b00, 0, 1, 1, 33'h608);
        // Redirect beats stall in HOLD
        step(1, 2'b11, 32'h700, 0, 1, NoChk);
        step(0, 2'b00, 0, 1, 0, 33'h700);
        // PC wrap
        step(1, 2'b11, 32'hFFFF_FFFF, 1, 0, 33'h704);
        step(0, 2'b00, 0, 1, 0, 33'hFFFF_FFFC);
        step(0, 2'b00, 0, 0, 0, 33'h0);
        // Reset in the middle of a drain
        step(1, 2'b11, 32'h800, 0, 0, 33'h0);
        branch_valid = 1'b1;
        pc_src = 2'b11;
        fetch_ack = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        checkEq("mid_rst_req", 32'(fetch_req), 32'd0);
        checkEq("mid_rst_valid", 32'(instr_valid), 32'd0);
        checkEq("mid_rst_flush", 32'(flush), 32'd0);
        checkEq("mid_rst_pc", pc, Rv);
        modelReset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step(0, 2'b00, 0, 1, 0, NoChk);
        step(0, 2'b00, 0, 1, 0, 33'h100);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            sepc = $urandom;
            mepc = $urandom;
            step(($urandom_range(3) == 0), 2'($urandom), $urandom,
                 ($urandom_range(1) == 1), ($urandom_range(3) == 0),
                 NoChk);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 nChecks, nErrors);
        $finish;
    end

endmodule
